riscv_ext_mem: RTL and testbench
================================

Name: riscv_ext_mem

Overview:
Word-organised data memory that sits directly downstream of the core's load/store unit and serves its memory interface (req/we/be/addr/wd in; rd/ready out).
- Models a slow external memory with a programmable number of wait states.
- The LSU stalls the core until ready_o is asserted.
- Byte-enable writes are performed here. Load data is returned as a full word, and the LSU extracts and extends it.

Parameters:
DEPTH, 1024, number of 32-bit words; must be a power of two.
LATENCY, 2, cycles from request acceptance to ready_o; legal range 1..15.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset, asynchronous, active-low.
mem_req_i  in  1  access request, held high by the LSU until ready_o.
mem_we_i  in  1  1 = write, 0 = read.
mem_be_i  in  4  byte enables for writes; bit n covers bits [8n+7:8n].
mem_addr_i  in  32  byte address.
mem_wd_i  in  32  write data, already lane-replicated by the LSU.
mem_rd_o  out  32  read data word.
mem_ready_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_i=0, takes effect immediately):
  - state=IDLE, wait counter=0, mem_ready_o=0, mem_rd_o=0.
  - Captured request registers are cleared.
  - Memory array contents are not reset and not altered.
  - A request in flight is dropped; its write is not performed.
- Word index = mem_addr_i[log2(DEPTH)+1:2].
  - Upper address bits are ignored, so accesses wrap modulo DEPTH words.
  - mem_addr_i[1:0] is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If mem_req_i=1 at an edge, capture we, be, word index and wd, and load the counter with LATENCY-1.
  - Go to DONE if LATENCY=1, otherwise go to BUSY.
  - If mem_req_i=0, stay in IDLE.
- BUSY:
  - Decrement the counter each edge.
  - On the edge where the counter equals 1, go to DONE.
  - On that same edge, perform the access:
    - Write: update only the bytes whose captured be bit is 1; other bytes keep their value.
    - Read: register the full word into mem_rd_o.
- When LATENCY=1, the access is performed on the accepting edge itself.
- DONE:
  - mem_ready_o=1 for exactly this one cycle; it is a registered output (state==DONE).
  - Next edge: always return to IDLE.
  - mem_req_i is ignored in DONE; it is the old request still held by the LSU.
- Latency: acceptance edge E0; mem_ready_o is high in the cycle following edge E(LATENCY-1), giving LATENCY cycles of stall.
- Back-to-back: a new request is accepted at the first edge in IDLE. The minimum request-to-request period is LATENCY+1 cycles.
- Input changes while in BUSY/DONE have no effect, because captured values are used.
- mem_rd_o holds its value until the next read completes.
  - Writes do not change mem_rd_o.
  - A write with be=0000 completes normally and changes nothing.
- Read-after-write to the same word in consecutive transactions returns the new data; there is no bypass hazard because accesses are serialised.

Decomposition:
- riscv_pkg gains:
  - Enum typedef mem_state_t {IDLE, BUSY, DONE}.
  - Constant MEM_WAIT_W=4 (counter width).
- Sub-module riscv_ext_mem_ram:
  - DEPTH×32 array with a synchronous write with 4-bit byte enables and a synchronous read.
  - Strobed by a single access-enable from the FSM.
- riscv_ext_mem contains the FSM, counter and capture registers.

Test Plan:
- Reset: assert rst_i=0 mid-cycle while in BUSY → mem_ready_o=0 and mem_rd_o=0 immediately, with no clock edge needed. After release, read the pending write's address → old value unchanged.
- Full-word write/read, LATENCY=2:
  - Write 0xDEADBEEF to 0x10 with be=1111 → ready pulses exactly 1 cycle, 2 cycles after acceptance.
  - Read 0x10 → mem_rd_o=0xDEADBEEF on the ready cycle.
- Byte/half enables:
  - Start with word 0x11223344 at 0x20.
  - Write wd=0xAAAAAAAA with be=0100 → read returns 0x11AA3344.
  - Then write wd=0xBBBBBBBB with be=0011 → read returns 0x11AABBBB.
- Held request: keep mem_req_i=1 continuously for 10 cycles with LATENCY=3 → exactly two ready pulses (cycle 3 and cycle 7). This confirms DONE ignores the held request and IDLE re-accepts it.
- Address wrap, DEPTH=1024: write 0x5A5A5A5A to byte address 0x1004 → a read of 0x0004 returns 0x5A5A5A5A. Low bits ignored: a read of 0x0007 also returns 0x5A5A5A5A.
- LATENCY=1 and be=0000:
  - Read → ready in the cycle right after acceptance.
  - Write with be=0000 → ready pulses, memory word unchanged, mem_rd_o keeps its previous value.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the external data memory model.
package riscv_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
  localparam int MEM_WAIT_W = 4;
endpackage

// File: rtl/riscv_ext_mem_ram.sv
// riscv_ext_mem_ram: word array with byte-enabled synchronous write and registered read.
module riscv_ext_mem_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wd_i,
  output logic [31:0]              rd_o
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q, rd_d;
  always_ff @(posedge clk_i) begin
    if (en_i && we_i)
      for (int i = 0; i < 4; i++)
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wd_i[8*i +: 8];
  end
  always_comb rd_d = (en_i && !we_i) ? mem[addr_i] : rd_q;
  // the array itself is never reset; only the read register is
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rd_q <= '0;
    else        rd_q <= rd_d;
  end
  assign rd_o = rd_q;
endmodule

// File: rtl/riscv_ext_mem.sv
// riscv_ext_mem: LSU-facing data memory with a programmable number of wait states.
module riscv_ext_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_ready_o
);
  localparam int AW = $clog2(DEPTH);
  mem_state_t            state_q, state_d;
  logic [MEM_WAIT_W-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [31:0]           wd_q, wd_d;
  logic                  acc_en;
  logic                  unused_addr;
  assign unused_addr = ^{mem_addr_i[31:AW+2], mem_addr_i[1:0]};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    acc_en  = 1'b0;
    case (state_q)
      IDLE: if (mem_req_i) begin
        we_d    = mem_we_i;
        be_d    = mem_be_i;
        idx_d   = mem_addr_i[AW+1:2];
        wd_d    = mem_wd_i;
        cnt_d   = MEM_WAIT_W'(LATENCY - 1);
        state_d = (LATENCY == 1) ? DONE : BUSY;
        acc_en  = (LATENCY == 1);
      end
      BUSY: begin
        cnt_d = cnt_q - MEM_WAIT_W'(1);
        if (cnt_q == MEM_WAIT_W'(1)) begin
          state_d = DONE;
          acc_en  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
    end
  end
  // the _d capture values equal the live inputs on the accepting edge, so one path serves both latencies
  riscv_ext_mem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (acc_en),
    .we_i   (we_d),
    .be_i   (be_d),
    .addr_i (idx_d),
    .wd_i   (wd_d),
    .rd_o   (mem_rd_o)
  );
  assign mem_ready_o = (state_q == DONE);
endmodule

// File: tb/tb_riscv_ext_mem.sv
// tb_riscv_ext_mem: scoreboard bench over three instances with LATENCY 2, 3 and 1.
module tb_riscv_ext_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req [3];
  logic        we  [3];
  logic [3:0]  be  [3];
  logic [31:0] addr[3];
  logic [31:0] wd  [3];
  logic [31:0] rd  [3];
  logic        rdy [3];
  int          lat [3] = '{2, 3, 1};

  typedef struct {int d; int cyc; logic [31:0] rd;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0, checks = 0, errors = 0;
  bit   prev[3] = '{0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    riscv_ext_mem #(.DEPTH(1024), .LATENCY(g == 0 ? 2 : g == 1 ? 3 : 1)) u (
      .clk_i       (clk),
      .rst_i       (rst),
      .mem_req_i   (req[g]),
      .mem_we_i    (we[g]),
      .mem_be_i    (be[g]),
      .mem_addr_i  (addr[g]),
      .mem_wd_i    (wd[g]),
      .mem_rd_o    (rd[g]),
      .mem_ready_o (rdy[g])
    );
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic expect_ready(input int d, input int at, input logic [31:0] erd);
    exp_t x;
    x.d = d; x.cyc = at; x.rd = erd;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rdy[d] === 1'b1) begin
        chk("ready_single_cycle", {31'b0, prev[d]}, 32'd0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_ready: dut%0d got ready with no expected response", d);
        end else begin
          mon_e = sb.pop_front();
          chk("ready_dut", d, mon_e.d);
          chk("ready_cycle", cyc, mon_e.cyc);
          chk("rd_data", rd[d], mon_e.rd);
        end
      end
      prev[d] = (rdy[d] === 1'b1);
    end
  end

  // called #1 after a rising edge; returns #1 after the edge that puts the DUT back in IDLE
  task automatic txn(input int d, input bit w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] data, input logic [31:0] erd);
    int n = 0;
    expect_ready(d, cyc + lat[d], erd);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wd[d] = data;
    do begin
      @(posedge clk); #1; n++;
    end while (rdy[d] !== 1'b1 && n < 40);
    if (rdy[d] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: dut%0d no ready after %0d cycles", d, n);
    end
    req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = 32'hFFFF_FFFC; wd[d] = 32'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = 32'h0; wd[d] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_rd", rd[d], 32'h0);
      chk("reset_ready", {31'b0, rdy[d]}, 32'h0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    // LATENCY=2: full word, byte lanes, address wrap
    txn(0, 1, 4'b1111, 32'h10,   32'hDEADBEEF, 32'h0);
    txn(0, 0, 4'b0000, 32'h10,   32'h0,        32'hDEADBEEF);
    txn(0, 1, 4'b1111, 32'h20,   32'h11223344, 32'hDEADBEEF);
    txn(0, 1, 4'b0100, 32'h20,   32'hAAAAAAAA, 32'hDEADBEEF);
    txn(0, 0, 4'b0000, 32'h20,   32'h0,        32'h11AA3344);
    txn(0, 1, 4'b0011, 32'h20,   32'hBBBBBBBB, 32'h11AA3344);
    txn(0, 0, 4'b0000, 32'h20,   32'h0,        32'h11AABBBB);
    txn(0, 1, 4'b1111, 32'h1004, 32'h5A5A5A5A, 32'h11AABBBB);
    txn(0, 0, 4'b0000, 32'h4,    32'h0,        32'h5A5A5A5A);
    txn(0, 0, 4'b0000, 32'h7,    32'h0,        32'h5A5A5A5A);
    // LATENCY=3: request held high, expect two completions four cycles apart
    expect_ready(1, cyc + 3, 32'h0);
    expect_ready(1, cyc + 7, 32'h0);
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h40; wd[1] = 32'h77;
    repeat (8) @(posedge clk);
    #1;
    req[1] = 1'b0; we[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("held_two_pulses", sb.size(), 32'd0);
    txn(1, 0, 4'b0000, 32'h40, 32'h0, 32'h77);
    // LATENCY=1 and empty byte enables
    txn(2, 1, 4'b1111, 32'h8, 32'h00001111, 32'h0);
    txn(2, 0, 4'b0000, 32'h8, 32'h0,        32'h00001111);
    txn(2, 1, 4'b0000, 32'h8, 32'hFFFFFFFF, 32'h00001111);
    txn(2, 0, 4'b0000, 32'h8, 32'h0,        32'h00001111);
    // asynchronous reset while a write is in BUSY
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h10; wd[0] = 32'h12345678;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_ready", {31'b0, rdy[0]}, 32'h0);
    chk("async_rst_rd", rd[0], 32'h0);
    chk("async_rst_rd_lat1", rd[2], 32'h0);
    req[0] = 1'b0; we[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(0, 0, 4'b0000, 32'h10, 32'h0, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
